uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, idle cycles allowed inside a locked packet before forced release.
REQ-003 SHALL have parameter BUSY_WAIT, default 15, max cycles waited for tx_busy to rise after tx_start.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port resetb  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-007 SHALL have port req_data  input  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_last  input  NREQ  byte is final byte of packet.
REQ-009 SHALL have port req_ready  output  NREQ  byte accepted this cycle (one-hot or zero).
REQ-010 SHALL have port tx_start  output  1  one-cycle launch pulse to UART serializer.
REQ-011 SHALL have port tx_data  output  8  byte to serializer; stable from tx_start until tx_busy falls.
REQ-012 SHALL have port tx_busy  input  1  serializer shifting.
REQ-013 SHALL have port grant_id  output  clog2(NREQ)  current owner; valid when active=1.
REQ-014 SHALL have port active  output  1  a requester holds the grant.
REQ-015 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM states IDLE, SEND, START, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if any req_valid, SHALL register round-robin winner (search starts at last_grant+1, wrapping) into grant_id, set active=1, go SEND next cycle; else stay.
REQ-018 SEND: when req_valid[grant_id]=1 and tx_busy=0, SHALL assert req_ready[grant_id] that cycle, capture req_data and req_last, go START.
REQ-019 START: SHALL drive tx_start=1 for exactly one cycle with captured tx_data, go WAIT_BUSY.
REQ-020 WAIT_BUSY: on tx_busy=1 go WAIT_DONE; after BUSY_WAIT cycles without it, SHALL go WAIT_DONE anyway.
REQ-021 WAIT_DONE: on tx_busy=0, captured last=1 -> IDLE, active=0, last_grant<=grant_id; last=0 -> SEND with grant locked.
REQ-022 Byte latency: req_ready cycle to tx_start cycle SHALL be exactly 1 cycle.
REQ-023 Locked SEND: cycles with req_valid[grant_id]=0 SHALL be counted; at LOCK_TIMEOUT SHALL pulse timeout_err, release to IDLE, last_grant<=grant_id; counter clears on each accepted byte.
REQ-024 First byte of a grant (unlocked SEND) SHALL not time out.
REQ-025 req_valid from non-granted requesters SHALL be ignored; req_ready SHALL never assert outside SEND.
REQ-026 Requester dropping req_valid while not accepted SHALL lose nothing; data sampled only in the req_ready cycle.
REQ-027 Simultaneous valid on all requesters SHALL grant in order last_grant+1, +2, ... over successive packets; no requester starves.
REQ-028 NREQ not power of two: round-robin SHALL wrap at NREQ-1 to 0.

Reset
REQ-029 On resetb=0, SHALL asynchronously force IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, timeout counter=0, last_grant=NREQ-1 (first grant favours requester 0).
REQ-030 Reset mid-packet SHALL abandon the byte; no tx_start after reset release until a new IDLE->SEND->START sequence.

Structure
REQ-031 State encoding and default parameters SHALL live in shared package uart_pkg.
REQ-032 Round-robin picker SHALL be a separate combinational sub-module rr_arbiter (inputs req, last_grant; outputs grant index, any).
REQ-033 Estimated size 150-300 lines RTL total.

Verification
REQ-034 Single packet: req 1 sends 0x0F,0x3D,0x4F(last) -> three tx_start pulses, tx_data 0x0F,0x3D,0x4F in order, grant_id=1 throughout, active falls after last tx_busy fall.
REQ-035 Contention: reqs 0,2,3 valid at once after reset, one-byte packets -> grant order 0,2,3; then req 0 again only after 3.
REQ-036 Locked packet: req 2 mid-packet, req 0 valid -> req 0 gets no req_ready until req 2 last byte completes.
REQ-037 Timeout: req 3 sends 0x29 (last=0) then drops valid -> timeout_err pulse exactly LOCK_TIMEOUT cycles after WAIT_DONE exit, active=0, next grant goes to req 0.
REQ-038 Missing busy: tx_busy held 0 -> WAIT_DONE entered BUSY_WAIT cycles after tx_start, no hang.
REQ-039 Reset mid-byte: resetb low during WAIT_DONE -> all outputs zero immediately, no tx_start for 3 cycles after release with no req_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit scheduler and its arbiter.
//   - Default parameter values for requester count, lock timeout and busy wait.
//   - Scheduler FSM state encoding.
//   - rr_wrap(): modulo-n wrap for a round-robin search index.
package uart_pkg;

  localparam int NREQ_DEF         = 4;
  localparam int LOCK_TIMEOUT_DEF = 1024;
  localparam int BUSY_WAIT_DEF    = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  // Search offsets never exceed 2*n-1, so a single subtraction is enough.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : most recent owner; the search starts one past it and wraps
//   grant      : index of the first requester found
//   any        : at least one request is present (grant is valid)
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] cand;

  // Scan last_grant+1 .. last_grant+NREQ (mod NREQ); the first hit wins,
  // so the previous owner is considered last.
  always_comb begin
    grant = {IW{1'b0}};
    any   = 1'b0;
    cand  = {IW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'(rr_wrap(int'(last_grant) + i, NREQ));
      if (!any && req[cand]) begin
        any   = 1'b1;
        grant = cand;
      end else begin
        any   = any;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: schedules byte streams from NREQ requesters onto one UART
// serializer. A requester owns the grant for a whole packet, which ends on a
// byte flagged req_last. It also ends after LOCK_TIMEOUT idle cycles inside
// the packet.
//   clock, resetb           : clock and asynchronous active-low reset
//   req_valid/data/last     : per-requester byte stream (byte i = req_data[8i+:8])
//   req_ready               : one-hot accept strobe, asserted only in SEND
//   tx_start, tx_data       : launch pulse and byte to the serializer
//   tx_busy                 : serializer is shifting
//   grant_id, active        : current owner and its valid flag
//   timeout_err             : one-cycle pulse when a locked packet is forced out
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int BUSY_WAIT    = BUSY_WAIT_DEF
) (
  input  logic                    clock,
  input  logic                    resetb,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  output logic                    timeout_err
);

  localparam int IW   = $clog2(NREQ);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int BW_W = $clog2(BUSY_WAIT + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic            active_q, active_d;
  logic            locked_q, locked_d;
  logic            last_q, last_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            timeout_q, timeout_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [BW_W-1:0] bw_cnt_q, bw_cnt_d;

  logic [IW-1:0]   arb_grant;
  logic            arb_any;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  assign sel_valid = req_valid[grant_q];
  assign sel_last  = req_last[grant_q];
  assign sel_data  = req_data[{grant_q, 3'b000} +: 8];

  // Next-state and handshake logic; req_ready is combinational so a byte is
  // accepted in the same cycle it is offered.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    active_d     = active_q;
    locked_d     = locked_q;
    last_d       = last_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    timeout_d    = 1'b0;
    to_cnt_d     = to_cnt_q;
    bw_cnt_d     = bw_cnt_q;
    req_ready    = {NREQ{1'b0}};

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d  = arb_grant;
          active_d = 1'b1;
          locked_d = 1'b0;
          to_cnt_d = {TO_W{1'b0}};
          state_d  = ST_SEND;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (sel_valid && !tx_busy) begin
          req_ready  = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
          tx_data_d  = sel_data;
          last_d     = sel_last;
          tx_start_d = 1'b1;
          to_cnt_d   = {TO_W{1'b0}};
          state_d    = ST_START;
        end else if (locked_q && !sel_valid) begin
          // Only a packet already under way can time out; the first byte of
          // a grant waits indefinitely.
          if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
            timeout_d    = 1'b1;
            active_d     = 1'b0;
            locked_d     = 1'b0;
            last_grant_d = grant_q;
            to_cnt_d     = {TO_W{1'b0}};
            state_d      = ST_IDLE;
          end else begin
            to_cnt_d     = to_cnt_q + TO_W'(1);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_START: begin
        // The START cycle itself is the first cycle spent without tx_busy.
        bw_cnt_d = BW_W'(1);
        state_d  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d  = ST_WAIT_DONE;
        end else if (bw_cnt_q >= BW_W'(BUSY_WAIT - 1)) begin
          state_d  = ST_WAIT_DONE;
        end else begin
          bw_cnt_d = bw_cnt_q + BW_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q) begin
            active_d     = 1'b0;
            locked_d     = 1'b0;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end else begin
            locked_d     = 1'b1;
            to_cnt_d     = {TO_W{1'b0}};
            state_d      = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        active_d = 1'b0;
        locked_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; last_grant resets to NREQ-1 so the first
  // search starts at requester 0.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      grant_q      <= {IW{1'b0}};
      last_grant_q <= IW'(NREQ - 1);
      active_q     <= 1'b0;
      locked_q     <= 1'b0;
      last_q       <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      timeout_q    <= 1'b0;
      to_cnt_q     <= {TO_W{1'b0}};
      bw_cnt_q     <= {BW_W{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      active_q     <= active_d;
      locked_q     <= locked_d;
      last_q       <= last_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      timeout_q    <= timeout_d;
      to_cnt_q     <= to_cnt_d;
      bw_cnt_q     <= bw_cnt_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched.
// Inputs change on the falling edge and outputs are sampled there or #1 later.
module tb_uart_tx_sched;

  localparam int LT = 20;
  localparam int BW = 6;

  logic        clk;
  logic        resetb;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_sched #(.NREQ(4), .LOCK_TIMEOUT(LT), .BUSY_WAIT(BW)) dut (
    .clock       (clk),
    .resetb      (resetb),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    resetb    = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_last  = 4'b0000;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clk);
    resetb = 1'b1;
  endtask

  // Offer one byte from requester id, wait for its accept, check the launch,
  // then act as the serializer for busy_cycles (0: never raise tx_busy and
  // return in the tx_start cycle).
  task automatic send_byte(input int id, input logic [7:0] d, input logic lst,
                           input int busy_cycles);
    int         waited;
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << id;
    @(negedge clk);
    req_valid[id]       = 1'b1;
    req_data[8*id +: 8] = d;
    req_last[id]        = lst;
    #1;
    waited = 0;
    while (req_ready == 4'b0000 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL ready id=%0d got %b want %b", id, req_ready, exp_rdy);
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== d || grant_id !== 2'(id) || active !== 1'b1) begin
      errors++;
      $display("FAIL launch id=%0d got start=%b data=%h grant=%0d active=%b want 1 %h %0d 1",
               id, tx_start, tx_data, grant_id, active, d, id);
    end
    if (busy_cycles > 0) begin
      tx_busy = 1'b1;
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0) begin
        errors++;
        $display("FAIL start_pulse id=%0d got %b want 0", id, tx_start);
      end
      repeat (busy_cycles - 1) @(negedge clk);
      tx_busy = 1'b0;
      @(negedge clk);
      checks++;
      if (active !== ~lst) begin
        errors++;
        $display("FAIL active_after id=%0d got %b want %b", id, active, ~lst);
      end
    end
  endtask

  task automatic test_reset();
    resetb    = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    req_last  = 4'b0000;
    tx_busy   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        grant_id !== 2'd0 || active !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset got rdy=%b start=%b data=%h grant=%0d act=%b to=%b want all 0",
               req_ready, tx_start, tx_data, grant_id, active, timeout_err);
    end
    resetb = 1'b1;
  endtask

  task automatic test_single_packet();
    send_byte(1, 8'h0F, 1'b0, 3);
    send_byte(1, 8'h3D, 1'b0, 3);
    send_byte(1, 8'h4F, 1'b1, 3);
  endtask

  task automatic test_contention();
    do_reset();
    @(negedge clk);
    req_valid = 4'b1101;
    req_data  = 32'h1312_0010;
    req_last  = 4'b1101;
    send_byte(0, 8'h10, 1'b1, 3);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h20;
    send_byte(2, 8'h12, 1'b1, 3);
    send_byte(3, 8'h13, 1'b1, 3);
    send_byte(0, 8'h20, 1'b1, 3);
  endtask

  task automatic test_locked();
    send_byte(2, 8'hA1, 1'b0, 3);
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h55;
    req_last[0]   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL locked_ignore cyc=%0d got %b want 0000", k, req_ready);
      end
    end
    send_byte(2, 8'hA2, 1'b1, 3);
    send_byte(0, 8'h55, 1'b1, 3);
  endtask

  task automatic test_timeout();
    send_byte(3, 8'h29, 1'b0, 3);
    checks++;
    if (timeout_err !== 1'b0 || active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_start got to=%b act=%b want 0 1", timeout_err, active);
    end
    for (int k = 1; k <= LT; k++) begin
      @(negedge clk);
      checks++;
      if (timeout_err !== (k == LT) || active !== (k != LT)) begin
        errors++;
        $display("FAIL timeout_cyc k=%0d got to=%b act=%b want %b %b",
                 k, timeout_err, active, (k == LT), (k != LT));
      end
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got %b want 0", timeout_err);
    end
    req_valid[1]  = 1'b1;
    req_data[15:8] = 8'h11;
    req_last[1]   = 1'b1;
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h66;
    req_last[0]   = 1'b1;
    send_byte(0, 8'h66, 1'b1, 3);
    req_valid[1] = 1'b0;
  endtask

  task automatic test_missing_busy();
    send_byte(2, 8'h77, 1'b1, 0);
    repeat (BW) @(negedge clk);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait_hold got act=%b want 1", active);
    end
    @(negedge clk);
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL busy_wait_exit got act=%b want 0", active);
    end
  endtask

  task automatic test_reset_mid_byte();
    send_byte(3, 8'hC3, 1'b0, 0);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 ||
        grant_id !== 2'd0 || active !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b start=%b data=%h grant=%0d act=%b to=%b want all 0",
               req_ready, tx_start, tx_data, grant_id, active, timeout_err);
    end
    @(negedge clk);
    tx_busy = 1'b0;
    resetb  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got start=%b act=%b want 0 0", k, tx_start, active);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_contention();
    test_locked();
    test_timeout();
    test_missing_busy();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
